// File: rtl/bcd7_scan.sv
// Multiplexed common-anode 7-segment driver: load-strobed shadow register, refresh scan,
// BCD/hex decode, per-digit enables and decimal points. Optional macro: BCD7_SCAN_LZ_BLANK_EN.
module bcd7_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int HEX_MODE    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              out,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] sh_val;
  logic [NUM_DIGITS-1:0]   sh_en;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   lz;

  logic                    cnt_wrap;
  logic [3:0]              sel_nib;
  logic                    sel_en;
  logic                    sel_dp;
  logic                    sel_lz;
  logic                    show;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0011000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    // In BCD mode the non-decimal codes show a lone dash (segment g).
    if (HEX_MODE == 0 && v > 4'd9) s = 7'b0111111;
    return s;
  endfunction

`ifdef BCD7_SCAN_LZ_BLANK_EN
  logic above_zero;

  // Walk from the leftmost digit down; disabled digits do not stop suppression.
  always_comb begin
    above_zero = 1'b1;
    lz         = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (k > 0)
        lz[k] = above_zero && (sh_val[4*k +: 4] == 4'h0) && !sh_dp[k];
      above_zero = above_zero && (!sh_en[k] || (sh_val[4*k +: 4] == 4'h0));
    end
  end
`else
  assign lz = '0;
`endif

  assign cnt_wrap = (cnt == CNT_LAST);

  always_comb begin
    sel_nib = 4'h0;
    sel_en  = 1'b0;
    sel_dp  = 1'b0;
    sel_lz  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        sel_nib = sh_val[4*k +: 4];
        sel_en  = sh_en[k];
        sel_dp  = sh_dp[k];
        sel_lz  = lz[k];
      end
    end
    show = en && sel_en && !sel_lz;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      sh_val     <= '0;
      sh_en      <= '0;
      sh_dp      <= '0;
      out        <= 7'b1111111;
      dp         <= 1'b1;
      an         <= '1;
      frame_tick <= 1'b0;
    end else begin
      if (cnt_wrap) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (load) begin
        sh_val <= in;
        sh_en  <= digit_en;
        sh_dp  <= dp_in;
      end
      // Outputs come from the pre-edge shadow and index, so a load never tears a digit.
      out        <= show ? seg_decode(sel_nib) : 7'b1111111;
      dp         <= show ? ~sel_dp : 1'b1;
      an         <= show ? ~(NUM_DIGITS'(1) << idx) : '1;
      frame_tick <= cnt_wrap && (idx == IDX_LAST);
    end
  end

endmodule

// File: tb/tb_bcd7_scan.sv
// Directed bench for bcd7_scan (4 digits, refresh divider 4), BCD and hex builds side by side.
module tb_bcd7_scan;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        load = 1'b0;
  logic [15:0] in = '0;
  logic [3:0]  digit_en = '0;
  logic [3:0]  dp_in = '0;

  logic [6:0]  out0, out1;
  logic        dp0, dp1, ft0, ft1;
  logic [3:0]  an0, an1;

  int n_tests = 0;
  int n_fail  = 0;
  string phase = "reset";

  // reference scan position and shadow contents
  int          cnt_m = 0;
  int          idx_m = 0;
  logic [15:0] sh_in = '0;
  logic [3:0]  sh_den = '0;
  logic [3:0]  sh_dp = '0;

  logic [6:0]  seen_out0 [4];
  logic [6:0]  seen_out1 [4];
  logic [3:0]  seen_an0 [4];
  logic        seen_dp0 [4];

  always #5 clk = ~clk;

  bcd7_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(0)) u_bcd (
    .clk(clk), .rst(rst), .en(en), .load(load), .in(in), .digit_en(digit_en),
    .dp_in(dp_in), .out(out0), .dp(dp0), .an(an0), .frame_tick(ft0)
  );

  bcd7_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(1)) u_hex (
    .clk(clk), .rst(rst), .en(en), .load(load), .in(in), .digit_en(digit_en),
    .dp_in(dp_in), .out(out1), .dp(dp1), .an(an1), .frame_tick(ft1)
  );

  task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %h expected %h", phase, tag, act, exp);
    end
  endtask

  // One clock edge: predict outputs from the pre-edge state, clock, compare, advance the model.
  task automatic step();
    logic [6:0] e_out0, e_out1;
    logic       e_dp, e_ft, show, hz;
    logic [3:0] e_an, nib;
    int         d;
    d = idx_m;
    nib = sh_in[4*d +: 4];
    show = en && sh_den[d];
`ifdef BCD7_SCAN_LZ_BLANK_EN
    if (d > 0 && nib == 4'h0 && !sh_dp[d]) begin
      hz = 1'b1;
      for (int j = d + 1; j < 4; j++)
        if (sh_den[j] && sh_in[4*j +: 4] != 4'h0) hz = 1'b0;
      if (hz) show = 1'b0;
    end
`else
    hz = 1'b0;
`endif
    if (rst) show = 1'b0;
    e_out0 = show ? ((nib > 4'd9) ? 7'b0111111 : SEG_TAB[nib]) : 7'b1111111;
    e_out1 = show ? SEG_TAB[nib] : 7'b1111111;
    e_dp   = show ? ~sh_dp[d] : 1'b1;
    e_an   = show ? ~(4'b0001 << d) : 4'b1111;
    e_ft   = !rst && (cnt_m == 3) && (idx_m == 3);

    @(posedge clk);
    #1;
    check_val("an", 16'(an0), 16'(e_an));
    check_val("out_bcd", 16'(out0), 16'(e_out0));
    check_val("dp", 16'(dp0), 16'(e_dp));
    check_val("frame_tick", 16'(ft0), 16'(e_ft));
    check_val("an_hex", 16'(an1), 16'(e_an));
    check_val("out_hex", 16'(out1), 16'(e_out1));
    check_val("an_onehot", 16'($countones(~an0) > 1), 16'd0);

    if (rst) begin
      cnt_m = 0;
      idx_m = 0;
      sh_in = '0;
      sh_den = '0;
      sh_dp = '0;
    end else begin
      seen_out0[d] = out0;
      seen_out1[d] = out1;
      seen_an0[d]  = an0;
      seen_dp0[d]  = dp0;
      if (load) begin
        sh_in  = in;
        sh_den = digit_en;
        sh_dp  = dp_in;
      end
      if (cnt_m == 3) begin
        cnt_m = 0;
        idx_m = (idx_m + 1) % 4;
      end else begin
        cnt_m++;
      end
    end
  endtask

  task automatic load_and_run(input logic [15:0] v, input logic [3:0] de,
                              input logic [3:0] dpv, input int n);
    in = v;
    digit_en = de;
    dp_in = dpv;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int guard;

    rst = 1'b1;
    run(2);
    check_val("rst_an", 16'(an0), 16'hf);
    check_val("rst_out", 16'(out0), 16'h7f);
    rst = 1'b0;

    phase = "h1234";
    load_and_run(16'h1234, 4'hF, 4'h0, 34);
    check_val("d3", 16'(seen_out0[3]), 16'(7'b1111001));
    check_val("d2", 16'(seen_out0[2]), 16'(7'b0100100));
    check_val("d1", 16'(seen_out0[1]), 16'(7'b0110000));
    check_val("d0", 16'(seen_out0[0]), 16'(7'b0011001));
    check_val("d2_an", 16'(seen_an0[2]), 16'(4'b1011));

    phase = "h00af";
    load_and_run(16'h00AF, 4'hF, 4'h0, 16);
    check_val("bcd_d0", 16'(seen_out0[0]), 16'(7'b0111111));
    check_val("bcd_d1", 16'(seen_out0[1]), 16'(7'b0111111));
    check_val("hex_d0", 16'(seen_out1[0]), 16'(7'b0001110));
    check_val("hex_d1", 16'(seen_out1[1]), 16'(7'b0001000));

    phase = "digit_en";
    load_and_run(16'h1234, 4'b0101, 4'b0001, 16);
    check_val("d1_an", 16'(seen_an0[1]), 16'hf);
    check_val("d1_out", 16'(seen_out0[1]), 16'h7f);
    check_val("d3_an", 16'(seen_an0[3]), 16'hf);
    check_val("d0_dp", 16'(seen_dp0[0]), 16'd0);
    check_val("d2_dp", 16'(seen_dp0[2]), 16'd1);

    phase = "en_off";
    en = 1'b0;
    run(33);
    check_val("d0_blank", 16'(seen_an0[0]), 16'hf);
    check_val("d2_blank", 16'(seen_out0[2]), 16'h7f);
    en = 1'b1;

    phase = "load_at_advance";
    guard = 0;
    while (cnt_m != 3 && guard < 8) begin
      step();
      guard++;
    end
    check_val("sync_timeout", 16'(cnt_m == 3), 16'd1);
    load_and_run(16'h5678, 4'hF, 4'h0, 8);

    phase = "rst_mid";
    guard = 0;
    while (!(idx_m == 2 && cnt_m == 1) && guard < 20) begin
      step();
      guard++;
    end
    check_val("sync_timeout", 16'(idx_m == 2 && cnt_m == 1), 16'd1);
    rst = 1'b1;
    step();
    check_val("an_after_rst", 16'(an0), 16'hf);
    check_val("out_after_rst", 16'(out0), 16'h7f);
    check_val("ft_after_rst", 16'(ft0), 16'd0);
    rst = 1'b0;
    run(20);
    for (int k = 0; k < 4; k++) check_val("blank_an", 16'(seen_an0[k]), 16'hf);

    phase = "lz_0070";
    load_and_run(16'h0070, 4'hF, 4'h0, 17);
    check_val("d1", 16'(seen_out0[1]), 16'(7'b1111000));
    check_val("d0", 16'(seen_out0[0]), 16'(7'b1000000));
`ifdef BCD7_SCAN_LZ_BLANK_EN
    check_val("d3_an", 16'(seen_an0[3]), 16'hf);
    check_val("d2_an", 16'(seen_an0[2]), 16'hf);
    check_val("d3_out", 16'(seen_out0[3]), 16'h7f);
`else
    check_val("d3_out", 16'(seen_out0[3]), 16'(7'b1000000));
    check_val("d2_out", 16'(seen_out0[2]), 16'(7'b1000000));
    check_val("d3_an", 16'(seen_an0[3]), 16'(4'b0111));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd7_scan.md
Name: bcd7_scan

Overview:
- Parametrised successor to the single-digit BCD/7-segment decoder. Drives NUM_DIGITS multiplexed, common-anode, active-low 7-segment digits from one shared segment bus.
- Holds the displayed value in a load-strobed shadow register, so the display never tears.
- Time-multiplexes the anodes with a refresh divider.
- Adds hex mode, per-digit enables and decimal points.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- REFRESH_DIV, 100000, clk cycles each digit is held active (>=2).
- HEX_MODE, 0, 0 = BCD decode (codes 10-15 show dash), 1 = hex decode 0-F.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global display enable; 0 blanks the display, scan keeps running.
- load  in  1  1 = capture in into the shadow register at this edge.
- in  in  4*NUM_DIGITS  packed nibbles; digit k = in[4k+3:4k], digit 0 is the rightmost.
- digit_en  in  NUM_DIGITS  per-digit enable, captured with load.
- dp_in  in  NUM_DIGITS  per-digit decimal point (1 = lit), captured with load.
- out  out  7  segments, active-low; out[0]=a .. out[6]=g.
- dp  out  1  decimal point, active-low.
- an  out  NUM_DIGITS  anodes, active-low, one-hot-low when active.
- frame_tick  out  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to digit 0.

Behaviour:
- Reset (rst=1 at an edge):
  - refresh counter=0, digit index=0.
  - shadow value=0, shadow digit_en=0, shadow dp=0.
  - out=7'b1111111, dp=1, an=all ones, frame_tick=0.
- Refresh counter:
  - counts 0..REFRESH_DIV-1 and wraps.
  - At terminal count the digit index advances, wrapping NUM_DIGITS-1 -> 0.
  - frame_tick=1 in the cycle after the wrap edge.
- Load:
  - load=1 writes in, digit_en and dp_in to the shadow at that edge.
  - load=0 holds the shadow.
  - Load does not affect counters.
- Outputs:
  - out, dp and an are registered every cycle from the current shadow and digit index, one cycle of latency.
  - Load and digit advance on the same edge: that edge's outputs use the old shadow and old index. The new values appear one edge later.
- Active digit i (en=1, shadow digit_en[i]=1):
  - an[i]=0, all other an bits =1.
  - out = decode of nibble i.
  - dp = ~shadow_dp[i].
- Disabled digit (shadow digit_en[i]=0) or en=0: an=all ones, out=7'b1111111, dp=1.
- Decode table (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000
  - HEX_MODE=1: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - HEX_MODE=0: codes 10-15 = 0111111 (dash, segment g only).
- Reset mid-scan: takes effect at the next edge regardless of counter state. The first post-reset edge drives digit 0, which is blanked because shadow digit_en=0.
- Widths: refresh counter is $clog2(REFRESH_DIV) bits; digit index is $clog2(NUM_DIGITS) bits (minimum 1).

Optional Feature:
- Macro BCD7_SCAN_LZ_BLANK_EN.
- Defined: leading-zero suppression.
  - A digit i>0 whose nibble is 0 is blanked (an=all ones, out=1111111, dp=1) when every enabled digit above it also holds 0.
  - Digit 0 is never suppressed.
  - Suppression is evaluated on the shadow register.
  - A digit with dp lit is not suppressed.
- Undefined: zeros are always displayed; no extra logic.

Test Plan:
- NUM_DIGITS=4, REFRESH_DIV=4. Reset, then load in=16'h1234, digit_en=4'hF, dp_in=0.
  - an sequence 1110,1101,1011,0111, each held 4 cycles.
  - out sequence 0011001 (4), 0110000 (3), 0100100 (2), 1111001 (1).
  - frame_tick pulses every 16 cycles.
- BCD mode, load in=16'h00AF.
  - Digits 0 and 1 show 0111111.
  - HEX_MODE=1 rebuild: digit 0=0001110, digit 1=0001000.
- digit_en=4'b0101, dp_in=4'b0001.
  - Digits 1 and 3 give an=1111, out=1111111.
  - Digit 0 gives dp=0.
  - en=0 blanks all digits while frame_tick keeps 16-cycle spacing.
- Assert load with in=16'h5678 on the exact edge the digit index advances.
  - Next displayed cycle still shows the old nibble.
  - New value appears one cycle later.
  - No illegal an pattern (more than one low bit).
- Pulse rst mid-digit 2.
  - Next edge: an=1111, out=1111111, frame_tick=0.
  - Counters restart at digit 0.
  - Shadow cleared: display blank until a load.
- With BCD7_SCAN_LZ_BLANK_EN, load in=16'h0070.
  - Digits 3 and 2 blanked, digit 1 shows 1111000, digit 0 shows 1000000.
  - Without the macro, digits 3 and 2 show 1000000.
